// File: rtl/simd_addsub_pipe.sv
// N-lane SIMD add/subtract with per-lane wrap/saturate and elastic handshake.
// S0 registers operands, S1 computes, later stages only delay the result.
module simd_addsub_pipe #(
    parameter int N      = 4,
    parameter int W      = 10,
    parameter int STAGES = 3,
    parameter int SIGNED = 0
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N*W-1:0] in_a,
    input  logic [N*W-1:0] in_b,
    input  logic [2*N-1:0] in_op,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N*W-1:0] out_sum,
    output logic [N-1:0]   out_ovf
);

    logic [STAGES-1:0] v_q, v_d;
    logic [STAGES:0]   rdy;

    logic [N*W-1:0] a_q, b_q;
    logic [2*N-1:0] op_q;

    logic [N*W-1:0] res_d;
    logic [N-1:0]   ovf_d;

    logic [N*W-1:0] sum_q [1:STAGES-1];
    logic [N-1:0]   ovf_q [1:STAGES-1];

    // A stage can advance if it or any stage below it is empty, or the sink takes.
    function automatic logic stage_ready(
        input logic [STAGES-1:0] v,
        input logic              ordy,
        input int                k
    );
        logic r;
        r = ordy;
        for (int j = k; j < STAGES; j++) r = r | !v[j];
        return r;
    endfunction

    // Returns {ovf, result}; the W+1-bit intermediate exposes carry/borrow/overflow.
    function automatic logic [W:0] lane_calc(
        input logic [W-1:0] a,
        input logic [W-1:0] b,
        input logic [1:0]   op
    );
        logic [W:0]   ext;
        logic         ovf;
        logic [W-1:0] sat;
        if (SIGNED != 0) begin
            ext = op[0] ? ({a[W-1], a} - {b[W-1], b})
                        : ({a[W-1], a} + {b[W-1], b});
            ovf = ext[W] ^ ext[W-1];
            sat = ext[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
        end else begin
            ext = op[0] ? ({1'b0, a} - {1'b0, b})
                        : ({1'b0, a} + {1'b0, b});
            ovf = ext[W];
            sat = op[0] ? '0 : '1;
        end
        return {ovf, (op[1] && ovf) ? sat : ext[W-1:0]};
    endfunction

    always_comb begin
        rdy[STAGES] = out_ready;
        for (int k = 0; k < STAGES; k++) rdy[k] = stage_ready(v_q, out_ready, k);
    end

    always_comb begin
        v_d = v_q;
        if (rdy[0]) v_d[0] = in_valid;
        for (int k = 1; k < STAGES; k++) begin
            if (rdy[k]) v_d[k] = v_q[k-1];
        end
    end

    always_comb begin
        res_d = '0;
        ovf_d = '0;
        for (int i = 0; i < N; i++) begin
            {ovf_d[i], res_d[i*W +: W]} =
                lane_calc(a_q[i*W +: W], b_q[i*W +: W], op_q[2*i +: 2]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q  <= '0;
            a_q  <= '0;
            b_q  <= '0;
            op_q <= '0;
            for (int k = 1; k < STAGES; k++) begin
                sum_q[k] <= '0;
                ovf_q[k] <= '0;
            end
        end else begin
            v_q <= v_d;
            if (rdy[0]) begin
                a_q  <= in_a;
                b_q  <= in_b;
                op_q <= in_op;
            end
            if (rdy[1]) begin
                sum_q[1] <= res_d;
                ovf_q[1] <= ovf_d;
            end
            for (int k = 2; k < STAGES; k++) begin
                if (rdy[k]) begin
                    sum_q[k] <= sum_q[k-1];
                    ovf_q[k] <= ovf_q[k-1];
                end
            end
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v_q[STAGES-1];
    assign out_sum   = sum_q[STAGES-1];
    assign out_ovf   = ovf_q[STAGES-1];

endmodule

// File: tb/tb_simd_addsub_pipe.sv
// Directed and streaming checks for simd_addsub_pipe, unsigned and signed builds.
// Expected values come from hand constants and an integer-range lane model.
module tb_simd_addsub_pipe;

    localparam int N  = 4;
    localparam int W  = 10;
    localparam int ST = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        u_iv, u_ir, u_ov, u_or;
    logic [39:0] u_a, u_b, u_sum;
    logic [7:0]  u_op;
    logic [3:0]  u_ovf;

    logic        s_iv, s_ir, s_ov, s_or;
    logic [39:0] s_a, s_b, s_sum;
    logic [7:0]  s_op;
    logic [3:0]  s_ovf;

    int tests = 0;
    int fails = 0;

    logic [39:0] sa [64];
    logic [39:0] sb [64];
    logic [7:0]  sop [64];
    logic [39:0] esum [64];
    logic [3:0]  eovf [64];

    always #5 clk = ~clk;

    simd_addsub_pipe #(.N(N), .W(W), .STAGES(ST), .SIGNED(0)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(u_iv), .in_ready(u_ir),
        .in_a(u_a), .in_b(u_b), .in_op(u_op),
        .out_valid(u_ov), .out_ready(u_or),
        .out_sum(u_sum), .out_ovf(u_ovf)
    );

    simd_addsub_pipe #(.N(N), .W(W), .STAGES(ST), .SIGNED(1)) s_dut (
        .clk(clk), .rst(rst),
        .in_valid(s_iv), .in_ready(s_ir),
        .in_a(s_a), .in_b(s_b), .in_op(s_op),
        .out_valid(s_ov), .out_ready(s_or),
        .out_sum(s_sum), .out_ovf(s_ovf)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Integer reference: exact result, then range test and clamp.
    function automatic void model(
        input bit sg, input logic [39:0] a, input logic [39:0] b,
        input logic [7:0] op, output logic [39:0] sum, output logic [3:0] ovf
    );
        int x, y, r, lo, hi;
        lo = sg ? -512 : 0;
        hi = sg ? 511 : 1023;
        for (int i = 0; i < N; i++) begin
            if (sg) begin
                x = $signed(a[i*W +: W]);
                y = $signed(b[i*W +: W]);
            end else begin
                x = int'(a[i*W +: W]);
                y = int'(b[i*W +: W]);
            end
            r = op[2*i] ? x - y : x + y;
            ovf[i] = (r < lo) || (r > hi);
            if (ovf[i] && op[2*i+1]) r = (r > hi) ? hi : lo;
            sum[i*W +: W] = r[9:0];
        end
    endfunction

    task automatic send(
        input bit sg, input logic [39:0] a, input logic [39:0] b, input logic [7:0] op,
        output logic [39:0] sum, output logic [3:0] ovf, output int lat
    );
        @(negedge clk);
        if (sg) begin
            s_a = a; s_b = b; s_op = op; s_iv = 1'b1; s_or = 1'b1;
        end else begin
            u_a = a; u_b = b; u_op = op; u_iv = 1'b1; u_or = 1'b1;
        end
        #1 chk(sg ? "s_in_ready" : "u_in_ready", sg ? s_ir : u_ir, 1);
        @(negedge clk);
        s_iv = 1'b0;
        u_iv = 1'b0;
        lat = 1;
        while (!(sg ? s_ov : u_ov) && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        #1;
        sum = sg ? s_sum : u_sum;
        ovf = sg ? s_ovf : u_ovf;
    endtask

    task automatic check_beat(
        input string tag, input bit sg,
        input logic [39:0] a, input logic [39:0] b, input logic [7:0] op,
        input logic [39:0] xs, input logic [3:0] xo
    );
        logic [39:0] sum, ms;
        logic [3:0]  ovf, mo;
        int          lat;
        send(sg, a, b, op, sum, ovf, lat);
        chk({tag, "_lat"}, lat, ST);
        for (int i = 0; i < N; i++) begin
            chk($sformatf("%s_sum%0d", tag, i), sum[i*W +: W], xs[i*W +: W]);
        end
        chk({tag, "_ovf"}, ovf, xo);
        model(sg, a, b, op, ms, mo);
        chk({tag, "_model_sum"}, sum, ms);
        chk({tag, "_model_ovf"}, ovf, mo);
    endtask

    task automatic stream(input bit rnd, input string tag);
        int          acc = 0, emit = 0, cyc = 0;
        int          first_acc = -1, first_emit = -1, last_emit = -1;
        logic        stall = 1'b0;
        logic [39:0] hs = '0;
        logic [3:0]  ho = '0;
        while (emit < 64 && cyc < 2000) begin
            @(negedge clk);
            u_or = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (acc < 64) begin
                u_iv = 1'b1; u_a = sa[acc]; u_b = sb[acc]; u_op = sop[acc];
            end else begin
                u_iv = 1'b0;
            end
            #1;
            if (stall) begin
                chk({tag, "_hold_v"}, u_ov, 1);
                chk({tag, "_hold_sum"}, u_sum, hs);
                chk({tag, "_hold_ovf"}, u_ovf, ho);
            end
            chk({tag, "_in_ready"}, u_ir, !((acc - emit) == ST && !u_or));
            if (u_ov && u_or) begin
                chk($sformatf("%s_sum[%0d]", tag, emit), u_sum, esum[emit]);
                chk($sformatf("%s_ovf[%0d]", tag, emit), u_ovf, eovf[emit]);
                if (first_emit < 0) first_emit = cyc;
                last_emit = cyc;
                emit++;
            end
            stall = u_ov && !u_or;
            hs = u_sum;
            ho = u_ovf;
            if (u_iv && u_ir) begin
                if (first_acc < 0) first_acc = cyc;
                acc++;
            end
            cyc++;
        end
        chk({tag, "_drained"}, emit, 64);
        if (!rnd) begin
            chk({tag, "_first_lat"}, first_emit - first_acc, ST);
            chk({tag, "_span"}, last_emit - first_emit, 63);
        end
        @(negedge clk);
        u_iv = 1'b0;
    endtask

    initial begin
        int vcount;
        u_iv = 0; u_a = '0; u_b = '0; u_op = '0; u_or = 1;
        s_iv = 0; s_a = '0; s_b = '0; s_op = '0; s_or = 1;

        #1;
        chk("rst_u_valid", u_ov, 0);
        chk("rst_u_sum", u_sum, 0);
        chk("rst_u_ovf", u_ovf, 0);
        chk("rst_s_valid", s_ov, 0);
        @(negedge clk);
        rst = 1'b0;

        check_beat("u_mixed", 1'b0,
            {10'd5, 10'd5, 10'd1000, 10'd1000},
            {10'd9, 10'd9, 10'd30, 10'd30},
            {2'b01, 2'b11, 2'b10, 2'b00},
            {10'd1020, 10'd0, 10'd1023, 10'd6}, 4'b1111);

        check_beat("u_noovf", 1'b0,
            {10'd7, 10'd1023, 10'd200, 10'd100},
            {10'd7, 10'd0, 10'd100, 10'd200},
            {2'b11, 2'b10, 2'b01, 2'b00},
            {10'd0, 10'd1023, 10'd100, 10'd300}, 4'b0000);

        check_beat("u_edge", 1'b0,
            {10'd0, 10'd1023, 10'd0, 10'd1023},
            {10'd0, 10'd1, 10'd1, 10'd1},
            {2'b11, 2'b10, 2'b01, 2'b00},
            {10'd0, 10'd1023, 10'd1023, 10'd0}, 4'b0111);

        check_beat("s_mixed", 1'b1,
            {10'h200, 10'h3FD, 10'h1F4, 10'h200},
            {10'h001, 10'h002, 10'h064, 10'h001},
            {2'b01, 2'b00, 2'b10, 2'b11},
            {10'h1FF, 10'h3FF, 10'h1FF, 10'h200}, 4'b1011);

        check_beat("s_edge", 1'b1,
            {10'h3FF, 10'h064, 10'h200, 10'h1FF},
            {10'h3FF, 10'h39C, 10'h3FF, 10'h001},
            {2'b01, 2'b11, 2'b10, 2'b00},
            {10'h000, 10'h0C8, 10'h200, 10'h200}, 4'b0011);

        for (int k = 0; k < 64; k++) begin
            sa[k]  = {$urandom, $urandom};
            sb[k]  = {$urandom, $urandom};
            sop[k] = 8'($urandom);
            model(1'b0, sa[k], sb[k], sop[k], esum[k], eovf[k]);
        end
        stream(1'b0, "str_full");
        stream(1'b1, "str_bp");

        @(negedge clk);
        u_or = 1'b0;
        for (int k = 0; k < 3; k++) begin
            u_iv = 1'b1; u_a = sa[k]; u_b = sb[k]; u_op = sop[k];
            @(negedge clk);
        end
        u_iv = 1'b0;
        #1 chk("rst_pre_valid", u_ov, 1);
        #1 rst = 1'b1;
        #1;
        chk("rst_async_valid", u_ov, 0);
        chk("rst_async_sum", u_sum, 0);
        chk("rst_async_ovf", u_ovf, 0);
        @(negedge clk);
        rst = 1'b0;
        u_or = 1'b1;
        vcount = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            #1 if (u_ov) vcount++;
        end
        chk("rst_no_stale", vcount, 0);

        check_beat("u_after_rst", 1'b0,
            {10'd7, 10'd1023, 10'd200, 10'd100},
            {10'd7, 10'd0, 10'd100, 10'd200},
            {2'b11, 2'b10, 2'b01, 2'b00},
            {10'd0, 10'd1023, 10'd100, 10'd300}, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/simd_addsub_pipe.md
Name: simd_addsub_pipe

Overview:
- N-lane, W-bit SIMD add/subtract datapath with a configurable pipeline depth and a per-lane operation select: wrap or saturate, signed or unsigned.
- Elastic valid/ready handshake on both sides, with full throughput and backpressure.
- Per-lane overflow flags.
- Sits between vector producers (filters, accumulators) and downstream consumers; intended to map onto DSP SIMD slices.

Parameters:
- N, 4, number of lanes.
- W, 10, lane width in bits, 2..48.
- STAGES, 3, pipeline depth (input to output latency in cycles), 2..6.
- SIGNED, 0, 1 = two's-complement lanes, 0 = unsigned lanes.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  module can accept a beat this cycle.
- in_a  in  N*W  operand A, lane i at bits [i*W +: W].
- in_b  in  N*W  operand B, same packing.
- in_op  in  2*N  per-lane op, lane i at [2i +: 2]: 00 add-wrap, 01 sub-wrap, 10 add-sat, 11 sub-sat.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the beat.
- out_sum  out  N*W  per-lane result.
- out_ovf  out  N  per-lane overflow/underflow flag for that beat.

Behaviour:
- Reset is asynchronous and active-high. While rst=1:
  - all stage valid bits are 0;
  - out_valid=0, out_sum=0, out_ovf=0.
  - Data registers may also be cleared.
- Reset asserted mid-stream discards all in-flight beats; no partial beat is emitted after release.
- Pipeline structure: STAGES register stages S0..S(STAGES-1), each with a valid bit v[k].
  - S0 captures in_a, in_b, in_op.
  - S1 computes: W+1-bit sum or difference, ovf flag, and saturation.
  - Remaining stages delay the result.
  - out_* are driven from the S(STAGES-1) registers.
- Handshake:
  - ready[k] = !v[k] | ready[k+1], with ready[STAGES] = out_ready.
  - in_ready = ready[0], combinational; there is no combinational path from in_valid to in_ready.
  - A transfer occurs on in_valid & in_ready, or on out_valid & out_ready.
  - Stage k loads from stage k-1 when ready[k]=1. v[k] <= v[k-1], with v[-1] = in_valid.
  - Stages that are not advancing hold their data.
- Latency and throughput:
  - With out_ready held at 1, a beat accepted at cycle t appears with out_valid=1 at cycle t+STAGES.
  - One beat per cycle is sustained.
  - Beat order is preserved. No beat is dropped or duplicated under any backpressure pattern.
- out_* remain stable while out_valid=1 and out_ready=0.
- Arithmetic, per lane, computed at W+1 bits:
  - Unsigned: add overflows when the carry-out is 1; sub underflows when a<b.
  - Signed: overflow when the operand signs (after B negation for sub) agree and the result sign differs.
  - Wrap ops (00, 01): out_sum = low W bits; out_ovf = overflow condition.
  - Sat ops (10, 11):
    - On overflow, clamp: unsigned to 2^W-1 (add) or 0 (sub); signed to 2^(W-1)-1 (positive overflow) or -2^(W-1) (negative overflow).
    - out_ovf=1 when clamping occurred.
- Lanes are fully independent; there is no carry between lanes.
- Simultaneous accept and emit in the same cycle at full occupancy is legal and must not stall.

Test Plan:
- W=10, unsigned, op=00: a=1000, b=30 -> out_sum=6, ovf=1. Same operands with op=10 -> out_sum=1023, ovf=1.
- Unsigned op=11: a=5, b=9 -> 0, ovf=1. Op=01 with the same operands -> 1020, ovf=1.
- SIGNED=1: op=11 with a=-512, b=1 -> -512, ovf=1. Op=10 with a=500, b=100 -> 511, ovf=1. Op=00 with a=-3, b=2 -> -1, ovf=0.
- Mixed lanes in one beat (ops 00, 01, 10, 11 on lanes 0..3) -> each lane matches its scalar reference; lanes do not interact.
- Streaming 64 random beats with out_ready held at 1 -> first output at cycle STAGES after the first accept, then one beat per cycle, in order. Repeat with random out_ready (50%) -> identical output sequence, out_* stable during stalls, in_ready=0 only when the pipe is full and stalled.
- Assert rst for one cycle with 3 beats in flight -> out_valid=0 asynchronously, no stale beats after release. The next accepted beat emerges after exactly STAGES cycles.
